// File: rtl/dsp_mac_seq_if.sv
// Operand-in and result-out handshake bundle for the sequential DSP MAC.
interface dsp_mac_seq_if;
    localparam int unsigned OP_W  = 18;
    localparam int unsigned ACC_W = 48;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [OP_W-1:0]  in_a;
    logic signed [OP_W-1:0]  in_b;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequences a signed multiply-accumulate job through an external DSP slice
// (A1/B1, MREG, OPMODEREG, PREG) and returns the 48-bit sum of products.
module dsp_mac_seq #(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    dsp_mac_seq_if.slave        bus,
    output logic signed [17:0]  dsp_a,
    output logic signed [17:0]  dsp_b,
    output logic [7:0]          dsp_opmode,
    output logic                dsp_cea,
    output logic                dsp_ceb,
    output logic                dsp_cem,
    output logic                dsp_cep,
    output logic                dsp_rstp,
    input  logic signed [47:0]  dsp_p,
    output logic                busy
);
    localparam int unsigned SR_W = PIPE_LAT - 1;
    localparam int unsigned DR_W = (SR_W > 1) ? $clog2(SR_W) : 1;
    localparam logic [7:0]  OPM_FIRST = 8'h01;
    localparam logic [7:0]  OPM_ACC   = 8'h09;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic [DR_W-1:0]    drain_q;
    logic [SR_W-1:0]    vld_sr;
    logic               in_ready_q, res_valid_q, busy_q, cap_q, rstp_q;
    logic [7:0]         opmode_q;
    logic signed [47:0] res_q;
    logic               accept, last_term, drain_end;

    assign accept    = bus.in_valid & in_ready_q;
    assign last_term = (cnt_q == (len_q - LEN_W'(1)));
    assign drain_end = (drain_q == DR_W'(SR_W - 1));

    // Operands and A/B enables go straight to the DSP input registers on accept.
    assign dsp_a   = accept ? bus.in_a : '0;
    assign dsp_b   = accept ? bus.in_b : '0;
    assign dsp_cea = accept;
    assign dsp_ceb = accept;
    assign dsp_cem = vld_sr[0];
    assign dsp_cep = vld_sr[SR_W-1];

    assign dsp_opmode    = opmode_q;
    assign dsp_rstp      = rstp_q;
    assign busy          = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    // P is first valid in the cycle DONE is entered; pass it through then and hold the copy after.
    assign bus.res_data  = cap_q ? dsp_p : res_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (accept && last_term) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job bookkeeping, pipeline tags and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            vld_sr      <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cap_q       <= 1'b0;
            opmode_q    <= 8'h00;
            res_q       <= '0;
        end else begin
            in_ready_q  <= (state_d == LOAD);
            res_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            cap_q       <= (state_q == DRAIN) && (state_d == DONE);
            vld_sr      <= {vld_sr[SR_W-2:0], accept};
            drain_q     <= (state_q == DRAIN) ? drain_q + DR_W'(1) : '0;
            if ((state_q == IDLE) && start) begin
                len_q <= len;
                cnt_q <= '0;
                res_q <= '0;
            end
            if (accept) begin
                cnt_q    <= cnt_q + LEN_W'(1);
                opmode_q <= (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
            end
            if (cap_q) begin
                res_q <= dsp_p;
            end
        end
    end

    // DSP P-register reset: covers reset and the first cycle after release.
    always_ff @(posedge clk) begin
        rstp_q <= !rst;
    end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural 3-stage DSP slice model.
module tb_dsp_mac_seq;
    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic signed [17:0] dsp_a, dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstp;
    logic signed [47:0] dsp_p;
    logic               busy;

    int checks = 0;
    int errors = 0;

    dsp_mac_seq_if bus ();

    dsp_mac_seq #(.LEN_W(8), .PIPE_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .bus        (bus),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_cea    (dsp_cea),
        .dsp_ceb    (dsp_ceb),
        .dsp_cem    (dsp_cem),
        .dsp_cep    (dsp_cep),
        .dsp_rstp   (dsp_rstp),
        .dsp_p      (dsp_p),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DSP slice model: A/B reg, M reg, OPMODE reg, P reg.
    logic signed [17:0] a_r, b_r;
    logic signed [35:0] m_r;
    logic [7:0]         opm_r;
    logic signed [47:0] p_r;

    always_ff @(posedge clk) begin
        if (dsp_cea) a_r <= dsp_a;
        if (dsp_ceb) b_r <= dsp_b;
        if (dsp_cem) m_r <= a_r * b_r;
        opm_r <= dsp_opmode;
        if (dsp_rstp) p_r <= '0;
        else if (dsp_cep) p_r <= (opm_r == 8'h09) ? p_r + 48'(m_r) : 48'(m_r);
    end
    assign dsp_p = p_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] r48(input logic [47:0] v);
        return {16'h0, v};
    endfunction

    task automatic handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("hs_res_valid", 64'(bus.res_valid), 64'd0);
        chk("hs_busy", 64'(busy), 64'd0);
    endtask

    logic signed [17:0] a2 [3];
    logic signed [17:0] b2 [3];

    initial begin
        a2 = '{-18'sd3, 18'sd7, 18'sd100};
        b2 = '{18'sd5, -18'sd2, 18'sd1};
        rst = 1'b0; start = 1'b0; len = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_data", r48(bus.res_data), 64'd0);
        chk("rst_cem", 64'(dsp_cem), 64'd0);
        chk("rst_cep", 64'(dsp_cep), 64'd0);
        chk("rst_cea", 64'(dsp_cea), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'd0);
        chk("rst_dsp_a", 64'(dsp_a), 64'd0);
        chk("rst_rstp", 64'(dsp_rstp), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstp_first_cycle", 64'(dsp_rstp), 64'd1);
        tick();
        chk("rstp_released", 64'(dsp_rstp), 64'd0);

        // V1: len=4, back-to-back accepts
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        chk("v1_in_ready", 64'(bus.in_ready), 64'd1);
        chk("v1_busy", 64'(busy), 64'd1);
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_a = 18'(i); bus.in_b = 18'sd2;
            #1;
            chk("v1_cea", 64'(dsp_cea), 64'd1);
            chk("v1_dsp_a", 64'(dsp_a), 64'(i));
            tick();
            if (i == 1) begin
                chk("v1_cem", 64'(dsp_cem), 64'd1);
                chk("v1_opmode_first", 64'(dsp_opmode), 64'h01);
            end
            if (i == 2) begin
                chk("v1_opmode_acc", 64'(dsp_opmode), 64'h09);
                chk("v1_cep", 64'(dsp_cep), 64'd1);
            end
        end
        bus.in_valid = 1'b0;
        chk("v1_in_ready_drop", 64'(bus.in_ready), 64'd0);
        tick();
        chk("v1_res_valid_early", 64'(bus.res_valid), 64'd0);
        tick();
        chk("v1_res_valid", 64'(bus.res_valid), 64'd1);
        chk("v1_res_data", r48(bus.res_data), 64'd20);
        handshake();

        // V2: len=3 with 2-cycle bubbles
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_a = a2[k]; bus.in_b = b2[k];
            #1;
            chk("v2_cea", 64'(dsp_cea), 64'd1);
            if (k > 0) begin
                chk("v2_cem_bubble", 64'(dsp_cem), 64'd0);
                chk("v2_cep_bubble", 64'(dsp_cep), 64'd0);
            end
            tick();
            bus.in_valid = 1'b0;
            #1;
            chk("v2_cea_gap", 64'(dsp_cea), 64'd0);
            if (k < 2) begin
                tick();
                chk("v2_cea_gap2", 64'(dsp_cea), 64'd0);
                chk("v2_opmode_hold", 64'(dsp_opmode), (k == 0) ? 64'h01 : 64'h09);
                tick();
            end
        end
        tick(); tick();
        chk("v2_res_valid", 64'(bus.res_valid), 64'd1);
        chk("v2_res_data", r48(bus.res_data), 64'd71);
        handshake();

        // V3: len=1, most negative operands
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 18'sh20000; bus.in_b = 18'sh20000;
        tick();
        bus.in_valid = 1'b0;
        chk("v3_opmode", 64'(dsp_opmode), 64'h01);
        chk("v3_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("v3_opmode_hold", 64'(dsp_opmode), 64'h01);
        tick();
        chk("v3_res_valid", 64'(bus.res_valid), 64'd1);
        chk("v3_res_data", r48(bus.res_data), r48(48'h0004_0000_0000));
        handshake();

        // V4: len=0 goes straight to DONE with zero
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("v4_res_valid", 64'(bus.res_valid), 64'd1);
        chk("v4_res_data", r48(bus.res_data), 64'd0);
        chk("v4_in_ready", 64'(bus.in_ready), 64'd0);
        chk("v4_cem", 64'(dsp_cem), 64'd0);
        chk("v4_cep", 64'(dsp_cep), 64'd0);
        tick();
        chk("v4_cep_later", 64'(dsp_cep), 64'd0);
        chk("v4_res_data_hold", r48(bus.res_data), 64'd0);
        handshake();

        // V5: back-pressure in DONE, start ignored
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 18'sd10; bus.in_b = 18'sd3;
        tick();
        bus.in_a = 18'sd20;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("v5_res_valid_hold", 64'(bus.res_valid), 64'd1);
            chk("v5_res_data_hold", r48(bus.res_data), 64'd90);
            start = 1'(i); len = 8'd1;
            tick();
        end
        start = 1'b1;
        handshake();
        start = 1'b0;
        chk("v5_in_ready_after", 64'(bus.in_ready), 64'd0);
        tick();
        chk("v5_single_result", 64'(bus.res_valid), 64'd0);
        chk("v5_idle_busy", 64'(busy), 64'd0);

        // V6: reset mid-job, then a fresh job
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 18'sd1; bus.in_b = 18'sd1;
        tick();
        bus.in_a = 18'sd2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("v6_in_ready", 64'(bus.in_ready), 64'd0);
        chk("v6_busy", 64'(busy), 64'd0);
        chk("v6_res_valid", 64'(bus.res_valid), 64'd0);
        chk("v6_res_data", r48(bus.res_data), 64'd0);
        chk("v6_cem", 64'(dsp_cem), 64'd0);
        chk("v6_cep", 64'(dsp_cep), 64'd0);
        chk("v6_opmode", 64'(dsp_opmode), 64'd0);
        chk("v6_rstp", 64'(dsp_rstp), 64'd1);
        rst = 1'b1;
        tick(); tick(); tick(); tick();
        chk("v6_no_result", 64'(bus.res_valid), 64'd0);
        chk("v6_idle", 64'(busy), 64'd0);
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 18'sd3; bus.in_b = 18'sd4;
        tick();
        bus.in_a = 18'sd5; bus.in_b = 18'sd6;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("v6_res_valid2", 64'(bus.res_valid), 64'd1);
        chk("v6_res_data2", r48(bus.res_data), 64'd42);
        handshake();

        // Maximum length job: 255 terms of 1 x -1
        start = 1'b1; len = 8'd255;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 18'sd1; bus.in_b = -18'sd1;
        repeat (255) tick();
        bus.in_valid = 1'b0;
        chk("max_in_ready", 64'(bus.in_ready), 64'd0);
        chk("max_busy", 64'(busy), 64'd1);
        tick();
        chk("max_res_valid_early", 64'(bus.res_valid), 64'd0);
        tick();
        chk("max_res_valid", 64'(bus.res_valid), 64'd1);
        chk("max_res_data", r48(bus.res_data), r48(48'hFFFF_FFFF_FF01));
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
